// File: rtl/pcie_trn_rx_buffer.sv
// -----------------------------------------------------------------------------
// pcie_trn_rx_buffer
// Packet-mode receive buffer for the Spartan-6 PCIe endpoint TRN RX interface.
// Whole TLPs are written into a circular FIFO. A TLP becomes visible to the
// fabric-side reader only once its eof beat has been committed. A TLP that is
// discontinued, that is cut off by an early sof, or that is oversized is rolled
// back and counted.
//
// Ports
//   trn_clk, trn_reset_n       : clock, async active-low reset
//   trn_rd/rsof_n/reof_n/rrem_n: TRN RX beat and framing (active-low)
//   trn_rsrc_rdy_n/rsrc_dsc_n  : source valid / discontinue (active-low)
//   trn_rbar_hit_n             : BAR hit, sampled on sof (active-low)
//   trn_rdst_rdy_n             : registered ready back to the endpoint
//   trn_rnp_ok_n               : registered non-posted OK
//   rx_valid/ready/data/sof/eof/half/bar : committed-packet output stream
//   dsc_count, ovf_count       : saturating drop counters
//
// Write FSM
//   state  | meaning
//   IDLE   | between packets, waiting for a sof beat
//   PKT    | packet in progress, beats written past commit_ptr
//   DROP   | oversized packet, discarding beats until eof/dsc
// -----------------------------------------------------------------------------
module pcie_trn_rx_buffer #(
  parameter int DEPTH_LOG2 = 5,
  parameter int NP_RESERVE = 8
) (
  input  logic        trn_clk,
  input  logic        trn_reset_n,
  input  logic [63:0] trn_rd,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rrem_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rsrc_dsc_n,
  input  logic [6:0]  trn_rbar_hit_n,
  output logic        trn_rdst_rdy_n,
  output logic        trn_rnp_ok_n,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [63:0] rx_data,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_half,
  output logic [6:0]  rx_bar,
  output logic [7:0]  dsc_count,
  output logic [7:0]  ovf_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EW    = 74;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PKT,
    S_DROP
  } wr_state_t;

  wr_state_t         r_state;
  wr_state_t         w_state_next;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_commit_ptr;
  logic [PW-1:0]     r_commit_rd;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_len;
  logic [6:0]        r_bar;
  logic [EW-1:0]     r_mem [DEPTH];
  logic              r_dst_rdy_n;
  logic              r_np_ok_n;
  logic              r_rx_valid;
  logic [EW-1:0]     r_rx_entry;
  logic [7:0]        r_dsc_count;
  logic [7:0]        r_ovf_count;

  logic [PW-1:0]     w_wr_next;
  logic [PW-1:0]     w_commit_next;
  logic [PW-1:0]     w_len_next;
  logic [PW-1:0]     w_base;
  logic [PW-1:0]     w_waddr;
  logic [6:0]        w_bar_next;
  logic [6:0]        w_wbar;
  logic [EW-1:0]     w_wdata;
  logic              w_we;
  logic              w_start;
  logic              w_dsc_inc;
  logic              w_ovf_inc;
  logic              w_in_xfer;
  logic              w_sof;
  logic              w_eof;
  logic              w_dsc;
  logic              w_out_xfer;
  logic [PW-1:0]     w_rd_next;
  logic              w_rd_avail;
  logic [PW-1:0]     w_used_next;
  logic [PW-1:0]     w_free_next;

  assign w_in_xfer  = ~trn_rsrc_rdy_n & ~r_dst_rdy_n;
  assign w_sof      = ~trn_rsof_n;
  assign w_eof      = ~trn_reof_n;
  assign w_dsc      = ~trn_rsrc_dsc_n;

  // ---------------------------------------------------------------------------
  // Write FSM, next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_wr_next     = r_wr_ptr;
    w_commit_next = r_commit_ptr;
    w_len_next    = r_len;
    w_bar_next    = r_bar;
    w_we          = 1'b0;
    w_waddr       = r_wr_ptr;
    w_dsc_inc     = 1'b0;
    w_ovf_inc     = 1'b0;
    w_start       = 1'b0;
    w_base        = r_wr_ptr;

    case (r_state)
      S_IDLE: begin
        if (w_in_xfer && w_sof) w_start = 1'b1;
      end
      S_PKT: begin
        if (w_dsc) begin
          w_wr_next    = r_commit_ptr;
          w_dsc_inc    = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_in_xfer && w_sof) begin
          // Early sof: drop the open packet and restart at the commit point.
          w_dsc_inc = 1'b1;
          w_start   = 1'b1;
          w_base    = r_commit_ptr;
        end else if (w_in_xfer) begin
          w_we      = 1'b1;
          w_waddr   = r_wr_ptr;
          w_wr_next = r_wr_ptr + PW'(1);
          if (w_eof) begin
            w_commit_next = r_wr_ptr + PW'(1);
            w_state_next  = S_IDLE;
          end else if (r_len + PW'(1) == PW'(DEPTH)) begin
            // Packet cannot fit even in an empty FIFO: give the space back.
            w_wr_next    = r_commit_ptr;
            w_ovf_inc    = 1'b1;
            w_state_next = S_DROP;
          end else begin
            w_len_next = r_len + PW'(1);
          end
        end
      end
      S_DROP: begin
        if (w_dsc || (w_in_xfer && w_eof)) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_start) begin
      w_we       = 1'b1;
      w_waddr    = w_base;
      w_wr_next  = w_base + PW'(1);
      w_bar_next = ~trn_rbar_hit_n;
      if (w_eof) begin
        w_commit_next = w_base + PW'(1);
        w_state_next  = S_IDLE;
      end else begin
        w_len_next   = PW'(1);
        w_state_next = S_PKT;
      end
    end
  end

  assign w_wbar  = w_start ? ~trn_rbar_hit_n : r_bar;
  assign w_wdata = {w_wbar, (trn_rrem_n & w_eof), w_eof, w_sof, trn_rd};

  // ---------------------------------------------------------------------------
  // Read side: rd_ptr points at the entry shown on the output register, so an
  // entry stays counted as used until the consumer takes it.
  // ---------------------------------------------------------------------------
  assign w_out_xfer  = r_rx_valid & rx_ready;
  assign w_rd_next   = r_rd_ptr + PW'(w_out_xfer);
  assign w_rd_avail  = (w_rd_next != r_commit_rd);
  assign w_used_next = w_wr_next - w_rd_next;
  assign w_free_next = PW'(DEPTH) - w_used_next;

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_commit_rd  <= '0;
      r_rd_ptr     <= '0;
      r_len        <= '0;
      r_bar        <= '0;
      r_dst_rdy_n  <= 1'b1;
      r_np_ok_n    <= 1'b1;
      r_rx_valid   <= 1'b0;
      r_rx_entry   <= '0;
      r_dsc_count  <= '0;
      r_ovf_count  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_wr_ptr     <= w_wr_next;
      r_commit_ptr <= w_commit_next;
      // One extra stage keeps a freshly committed entry's write well clear
      // of the show-ahead read.
      r_commit_rd  <= r_commit_ptr;
      r_rd_ptr     <= w_rd_next;
      r_len        <= w_len_next;
      r_bar        <= w_bar_next;
      r_dst_rdy_n  <= ~((w_free_next >= PW'(1)) || (w_state_next == S_DROP));
      r_np_ok_n    <= ~(w_free_next >= PW'(NP_RESERVE));
      r_rx_valid   <= w_rd_avail;
      r_rx_entry   <= w_rd_avail ? r_mem[w_rd_next[DEPTH_LOG2-1:0]] : '0;
      if (w_dsc_inc && (r_dsc_count != 8'hFF)) r_dsc_count <= r_dsc_count + 8'd1;
      if (w_ovf_inc && (r_ovf_count != 8'hFF)) r_ovf_count <= r_ovf_count + 8'd1;
    end
  end

  always_ff @(posedge trn_clk) begin
    if (w_we) r_mem[w_waddr[DEPTH_LOG2-1:0]] <= w_wdata;
  end

  assign trn_rdst_rdy_n = r_dst_rdy_n;
  assign trn_rnp_ok_n   = r_np_ok_n;
  assign rx_valid       = r_rx_valid;
  assign rx_data        = r_rx_entry[63:0];
  assign rx_sof         = r_rx_entry[64];
  assign rx_eof         = r_rx_entry[65];
  assign rx_half        = r_rx_entry[66];
  assign rx_bar         = r_rx_entry[73:67];
  assign dsc_count      = r_dsc_count;
  assign ovf_count      = r_ovf_count;

endmodule

// File: tb/tb_pcie_trn_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_pcie_trn_rx_buffer
// Directed bench for pcie_trn_rx_buffer (DEPTH_LOG2=5, NP_RESERVE=8).
// Output beats are captured at the falling edge into a queue and compared with
// hand-computed expected beats.
// -----------------------------------------------------------------------------
module tb_pcie_trn_rx_buffer;

  logic        trn_clk = 1'b0;
  logic        trn_reset_n;
  logic [63:0] trn_rd;
  logic        trn_rsof_n, trn_reof_n, trn_rrem_n;
  logic        trn_rsrc_rdy_n, trn_rsrc_dsc_n;
  logic [6:0]  trn_rbar_hit_n;
  logic        trn_rdst_rdy_n, trn_rnp_ok_n;
  logic        rx_valid, rx_ready;
  logic [63:0] rx_data;
  logic        rx_sof, rx_eof, rx_half;
  logic [6:0]  rx_bar;
  logic [7:0]  dsc_count, ovf_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_cnt = 0;
  int last_acc_edge = 0;
  int first_valid_edge = -1;
  logic lat_arm = 1'b0;
  logic [73:0] cap_q[$];

  pcie_trn_rx_buffer #(.DEPTH_LOG2(5), .NP_RESERVE(8)) dut (
    .trn_clk        (trn_clk),
    .trn_reset_n    (trn_reset_n),
    .trn_rd         (trn_rd),
    .trn_rsof_n     (trn_rsof_n),
    .trn_reof_n     (trn_reof_n),
    .trn_rrem_n     (trn_rrem_n),
    .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n (trn_rsrc_dsc_n),
    .trn_rbar_hit_n (trn_rbar_hit_n),
    .trn_rdst_rdy_n (trn_rdst_rdy_n),
    .trn_rnp_ok_n   (trn_rnp_ok_n),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .rx_sof         (rx_sof),
    .rx_eof         (rx_eof),
    .rx_half        (rx_half),
    .rx_bar         (rx_bar),
    .dsc_count      (dsc_count),
    .ovf_count      (ovf_count)
  );

  always #5 trn_clk = ~trn_clk;

  always @(posedge trn_clk) cyc <= cyc + 1;

  always @(negedge trn_clk) begin
    if (rx_valid && rx_ready) cap_q.push_back({rx_bar, rx_half, rx_eof, rx_sof, rx_data});
    if (lat_arm && rx_valid && first_valid_edge < 0) first_valid_edge = cyc;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rrem_n     = 1'b0;
    trn_rsrc_dsc_n = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat's acceptance edge.
  task automatic send_beat(input logic [63:0] d, input logic sof, input logic eof,
                           input logic rrem_n, input logic [6:0] barn, input logic dsc);
    int n;
    n = 0;
    trn_rd         = d;
    trn_rsof_n     = ~sof;
    trn_reof_n     = ~eof;
    trn_rrem_n     = rrem_n;
    trn_rbar_hit_n = barn;
    trn_rsrc_dsc_n = ~dsc;
    trn_rsrc_rdy_n = 1'b0;
    @(negedge trn_clk);
    while (trn_rdst_rdy_n && n < 200) begin
      stall_cnt++;
      n++;
      @(negedge trn_clk);
    end
    if (n >= 200) check_val("rdy_timeout", trn_rdst_rdy_n, 0);
    last_acc_edge = cyc + 1;
    @(posedge trn_clk);
    #1;
    idle_in();
  endtask

  task automatic wait_out(input int n, input string tag);
    int k;
    k = 0;
    while (cap_q.size() < n && k < 300) begin
      @(posedge trn_clk);
      k++;
    end
    repeat (8) @(posedge trn_clk);
    #1;
    check_val(tag, cap_q.size(), n);
  endtask

  task automatic expect_beat(input string tag, input int idx, input logic [63:0] d,
                             input logic sof, input logic eof, input logic half,
                             input logic [6:0] bar);
    logic [9:0] flags;
    if (idx < cap_q.size()) begin
      flags = cap_q[idx][73:64];
      check_val({tag, "_data"}, cap_q[idx][63:0], d);
      check_val({tag, "_flags"}, {54'd0, flags}, {54'd0, bar, half, eof, sof});
    end else begin
      check_val({tag, "_missing"}, cap_q.size(), idx + 1);
    end
  endtask

  initial begin
    trn_reset_n    = 1'b0;
    trn_rd         = '0;
    trn_rbar_hit_n = 7'h7F;
    rx_ready       = 1'b1;
    idle_in();

    // Reset state
    repeat (3) @(posedge trn_clk);
    #1;
    check_val("rst_rdy_n", trn_rdst_rdy_n, 1);
    check_val("rst_np_ok_n", trn_rnp_ok_n, 1);
    check_val("rst_valid", rx_valid, 0);
    check_val("rst_data", rx_data, 0);
    check_val("rst_dsc", dsc_count, 0);
    check_val("rst_ovf", ovf_count, 0);
    trn_reset_n = 1'b1;
    @(posedge trn_clk);
    #1;
    check_val("rel_rdy_n", trn_rdst_rdy_n, 0);
    check_val("rel_np_ok_n", trn_rnp_ok_n, 0);

    // Single 3-beat TLP, bar_hit_n=7E, half on eof
    cap_q.delete();
    first_valid_edge = -1;
    lat_arm = 1'b1;
    send_beat(64'h1111_0000_0000_0000, 1, 0, 0, 7'h7E, 0);
    send_beat(64'h1111_0000_0000_0001, 0, 0, 0, 7'h7F, 0);
    send_beat(64'h1111_0000_0000_0002, 0, 1, 1, 7'h7F, 0);
    wait_out(3, "t1_count");
    lat_arm = 1'b0;
    check_val("t1_latency", 64'(first_valid_edge - last_acc_edge), 2);
    expect_beat("t1_b0", 0, 64'h1111_0000_0000_0000, 1, 0, 0, 7'h01);
    expect_beat("t1_b1", 1, 64'h1111_0000_0000_0001, 0, 0, 0, 7'h01);
    expect_beat("t1_b2", 2, 64'h1111_0000_0000_0002, 0, 1, 1, 7'h01);

    // Discontinue on beat 3 of a 4-beat TLP, then a 2-beat TLP
    cap_q.delete();
    send_beat(64'h2222_0000_0000_0000, 1, 0, 0, 7'h7D, 0);
    send_beat(64'h2222_0000_0000_0001, 0, 0, 0, 7'h7F, 0);
    send_beat(64'h2222_0000_0000_0002, 0, 0, 0, 7'h7F, 1);
    send_beat(64'h2222_0000_0000_0003, 0, 1, 0, 7'h7F, 0);
    send_beat(64'h3333_0000_0000_0000, 1, 0, 0, 7'h7B, 0);
    send_beat(64'h3333_0000_0000_0001, 0, 1, 0, 7'h7F, 0);
    wait_out(2, "t2_count");
    expect_beat("t2_b0", 0, 64'h3333_0000_0000_0000, 1, 0, 0, 7'h04);
    expect_beat("t2_b1", 1, 64'h3333_0000_0000_0001, 0, 1, 0, 7'h04);
    check_val("t2_dsc", dsc_count, 1);

    // Oversized 40-beat TLP, then a 1-beat TLP
    cap_q.delete();
    stall_cnt = 0;
    for (int i = 0; i < 40; i++)
      send_beat(64'h4444_0000_0000_0000 + 64'(i), (i == 0), (i == 39), 0, 7'h77, 0);
    check_val("t3_stalls", stall_cnt, 0);
    send_beat(64'h5555_0000_0000_0000, 1, 1, 0, 7'h6F, 0);
    wait_out(1, "t3_count");
    expect_beat("t3_b0", 0, 64'h5555_0000_0000_0000, 1, 1, 0, 7'h10);
    check_val("t3_ovf", ovf_count, 1);
    check_val("t3_dsc", dsc_count, 1);

    // Backpressure: 8 four-beat TLPs with the consumer stalled
    cap_q.delete();
    rx_ready = 1'b0;
    for (int p = 0; p < 8; p++) begin
      for (int b = 0; b < 4; b++) begin
        send_beat({32'hC0DE_0000, 32'(p * 16 + b)}, (b == 0), (b == 3), p[0],
                  ~7'(p + 1), 0);
        if (p * 4 + b == 23) check_val("t4_np_ok_24", trn_rnp_ok_n, 0);
        if (p * 4 + b == 24) check_val("t4_np_ok_25", trn_rnp_ok_n, 1);
        if (p * 4 + b == 30) check_val("t4_rdy_31", trn_rdst_rdy_n, 0);
      end
    end
    repeat (3) @(posedge trn_clk);
    #1;
    check_val("t4_rdy_full", trn_rdst_rdy_n, 1);
    check_val("t4_np_full", trn_rnp_ok_n, 1);
    check_val("t4_held", cap_q.size(), 0);
    rx_ready = 1'b1;
    wait_out(32, "t4_count");
    for (int p = 0; p < 8; p++)
      for (int b = 0; b < 4; b++)
        expect_beat("t4_beat", p * 4 + b, {32'hC0DE_0000, 32'(p * 16 + b)},
                    (b == 0), (b == 3), (b == 3) && p[0], 7'(p + 1));
    check_val("t4_rdy_after", trn_rdst_rdy_n, 0);

    // Framing errors: stray beat in IDLE, then early sof mid-packet
    cap_q.delete();
    send_beat(64'h0BAD_0000_0000_0000, 0, 1, 0, 7'h7F, 0);
    send_beat(64'h6666_0000_0000_0000, 1, 0, 0, 7'h7E, 0);
    send_beat(64'h6666_0000_0000_0001, 0, 0, 0, 7'h7F, 0);
    send_beat(64'h7777_0000_0000_0000, 1, 0, 0, 7'h3F, 0);
    send_beat(64'h7777_0000_0000_0001, 0, 0, 0, 7'h7F, 0);
    send_beat(64'h7777_0000_0000_0002, 0, 1, 0, 7'h7F, 0);
    wait_out(3, "t5_count");
    expect_beat("t5_b0", 0, 64'h7777_0000_0000_0000, 1, 0, 0, 7'h40);
    expect_beat("t5_b1", 1, 64'h7777_0000_0000_0001, 0, 0, 0, 7'h40);
    expect_beat("t5_b2", 2, 64'h7777_0000_0000_0002, 0, 1, 0, 7'h40);
    check_val("t5_dsc", dsc_count, 2);

    // Reset mid-packet after 2 beats
    cap_q.delete();
    send_beat(64'h8888_0000_0000_0000, 1, 0, 0, 7'h7E, 0);
    send_beat(64'h8888_0000_0000_0001, 0, 0, 0, 7'h7F, 0);
    #3;
    trn_reset_n = 1'b0;
    #1;
    check_val("t6_rdy_n", trn_rdst_rdy_n, 1);
    check_val("t6_np_ok_n", trn_rnp_ok_n, 1);
    check_val("t6_valid", rx_valid, 0);
    check_val("t6_dsc", dsc_count, 0);
    check_val("t6_ovf", ovf_count, 0);
    @(posedge trn_clk);
    @(posedge trn_clk);
    #1;
    trn_reset_n = 1'b1;
    @(posedge trn_clk);
    #1;
    send_beat(64'h9999_0000_0000_0000, 1, 0, 0, 7'h7D, 0);
    send_beat(64'h9999_0000_0000_0001, 0, 1, 1, 7'h7F, 0);
    wait_out(2, "t6_count");
    expect_beat("t6_b0", 0, 64'h9999_0000_0000_0000, 1, 0, 0, 7'h02);
    expect_beat("t6_b1", 1, 64'h9999_0000_0000_0001, 0, 1, 1, 7'h02);
    check_val("t6_dsc_after", dsc_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
